// File: rtl/dekatron_pkg.sv
// ----------------------------------------------------------------------------
// dekatron_pkg
// Shared types and default parameters for the dekatron guide-pulse decoder.
//   dek_dec_state_t : decoder FSM states
//   *_DEF           : default parameter values used by the decoder and counter
// ----------------------------------------------------------------------------
package dekatron_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P1    = 3'd1,
        GAP   = 3'd2,
        P2    = 3'd3,
        FAULT = 3'd4
    } dek_dec_state_t;

    localparam int N_CATHODES_DEF = 10;
    localparam int MIN_WIDTH_DEF  = 2;
    localparam int MAX_WIDTH_DEF  = 8;
    localparam int MAX_GAP_DEF    = 4;

endpackage

// File: rtl/dekatron_ring_counter.sv
// ----------------------------------------------------------------------------
// dekatron_ring_counter
// Mod-N up/down position counter with synchronous load, wrap strobes and a
// registered one-hot cathode decode.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load         load load_val into the position (values >= N load 0)
//   load_val     BCD load value
//   step_en      commit one step this cycle (ignored while load is high)
//   step_dec     direction of the step: 1 = -1, 0 = +1
//   position     current position 0..N-1
//   cathodes     one-hot of position, bit0 = cathode 0
//   step         1-cycle strobe after a committed step
//   last_dec     direction of the most recent committed step
//   carry        1-cycle strobe on the N-1 -> 0 increment wrap
//   borrow       1-cycle strobe on the 0 -> N-1 decrement wrap
// ----------------------------------------------------------------------------
module dekatron_ring_counter
    import dekatron_pkg::*;
#(
    parameter  int N  = N_CATHODES_DEF,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    input  logic          step_en,
    input  logic          step_dec,
    output logic [PW-1:0] position,
    output logic [N-1:0]  cathodes,
    output logic          step,
    output logic          last_dec,
    output logic          carry,
    output logic          borrow
);

    localparam logic [PW-1:0] TOP = PW'(N - 1);
    localparam logic [PW-1:0] INC = PW'(1);
    localparam logic [N-1:0]  ONE = N'(1);

    logic [PW-1:0] pos_nxt;
    logic          carry_nxt;
    logic          borrow_nxt;
    logic          do_step;

    // Load wins over a same-cycle step so a step never lands on top of a load.
    assign do_step = step_en && !load;

    always_comb begin
        pos_nxt    = position;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (load) begin
            pos_nxt = (int'(load_val) >= N) ? '0 : load_val;
        end else if (step_en) begin
            if (!step_dec) begin
                if (position == TOP) begin
                    pos_nxt   = '0;
                    carry_nxt = 1'b1;
                end else begin
                    pos_nxt = position + INC;
                end
            end else begin
                if (position == '0) begin
                    pos_nxt    = TOP;
                    borrow_nxt = 1'b1;
                end else begin
                    pos_nxt = position - INC;
                end
            end
        end
    end

    // Cathodes is decoded from pos_nxt so it is registered alongside position
    // and can never be zero or multi-hot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            position <= '0;
            cathodes <= ONE;
            step     <= 1'b0;
            last_dec <= 1'b0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
        end else begin
            position <= pos_nxt;
            cathodes <= ONE << pos_nxt;
            step     <= do_step;
            carry    <= carry_nxt;
            borrow   <= borrow_nxt;
            if (do_step) begin
                last_dec <= step_dec;
            end
        end
    end

endmodule

// File: rtl/dekatron_pulse_decoder.sv
// ----------------------------------------------------------------------------
// dekatron_pulse_decoder
// Receive end of the dekatron two-guide stepping interface. Decodes each
// complete {Right, Left} guide-pulse pair into a +1/-1 step of a shadow
// position and flags malformed sequences (overlap, glitch, stuck, orphan).
// Right then Left = increment; Left then Right = decrement.
// Ports:
//   hsClk      clock; guide pulses are already in this domain
//   Rst_n      synchronous active-low reset
//   PulsesIn   {Right, Left} guide pulses
//   Set, In    synchronous load of In into the position (In >= N loads 0)
//   Position   current BCD position
//   Cathodes   one-hot of Position
//   Step       1-cycle strobe per committed step
//   StepDec    direction of the last step (1 = -1), qualified by Step
//   Carry      1-cycle strobe on the 9 -> 0 increment wrap
//   Borrow     1-cycle strobe on the 0 -> 9 decrement wrap
//   Err        1-cycle strobe on entry to FAULT
//   Busy       FSM not in IDLE
// ----------------------------------------------------------------------------
module dekatron_pulse_decoder
    import dekatron_pkg::*;
#(
    parameter  int N_CATHODES = N_CATHODES_DEF,
    parameter  int MIN_WIDTH  = MIN_WIDTH_DEF,
    parameter  int MAX_WIDTH  = MAX_WIDTH_DEF,
    parameter  int MAX_GAP    = MAX_GAP_DEF,
    localparam int PW         = $clog2(N_CATHODES),
    localparam int CW         = $clog2(MAX_WIDTH + 1)
) (
    input  logic                  hsClk,
    input  logic                  Rst_n,
    input  logic [1:0]            PulsesIn,
    input  logic                  Set,
    input  logic [PW-1:0]         In,
    output logic [PW-1:0]         Position,
    output logic [N_CATHODES-1:0] Cathodes,
    output logic                  Step,
    output logic                  StepDec,
    output logic                  Carry,
    output logic                  Borrow,
    output logic                  Err,
    output logic                  Busy
);

    localparam logic [CW-1:0] MIN_C = CW'(MIN_WIDTH);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WIDTH);
    localparam logic [CW-1:0] GAP_C = CW'(MAX_GAP);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    dek_dec_state_t state, state_nxt;
    logic [CW-1:0]  wcnt, wcnt_nxt;
    logic [CW-1:0]  gcnt, gcnt_nxt;
    logic           dir_dec, dir_dec_nxt;
    logic           err_q;
    logic           commit;
    logic           enter_fault;
    logic           first_hi;
    logic           second_hi;
    logic           both_hi;
    logic           both_lo;

    // "first" and "second" are relative to the latched direction: for an
    // increment Right is first, for a decrement Left is first.
    assign first_hi  = dir_dec ? PulsesIn[0] : PulsesIn[1];
    assign second_hi = dir_dec ? PulsesIn[1] : PulsesIn[0];
    assign both_hi   = &PulsesIn;
    assign both_lo   = ~|PulsesIn;

    always_ff @(posedge hsClk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            wcnt    <= '0;
            gcnt    <= '0;
            dir_dec <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            gcnt    <= gcnt_nxt;
            dir_dec <= dir_dec_nxt;
            err_q   <= enter_fault;
        end
    end

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        gcnt_nxt    = gcnt;
        dir_dec_nxt = dir_dec;
        commit      = 1'b0;

        case (state)
            IDLE: begin
                if (both_hi) begin
                    state_nxt = FAULT;
                end else if (!both_lo) begin
                    state_nxt   = P1;
                    dir_dec_nxt = PulsesIn[0];
                    wcnt_nxt    = ONE_C;
                end
            end
            P1: begin
                if (both_hi) begin
                    state_nxt = FAULT;
                end else if (first_hi) begin
                    if (wcnt >= MAX_C) state_nxt = FAULT;
                    else               wcnt_nxt  = wcnt + ONE_C;
                end else if (second_hi) begin
                    if (wcnt >= MIN_C) begin
                        state_nxt = P2;
                        wcnt_nxt  = ONE_C;
                    end else begin
                        state_nxt = FAULT;
                    end
                end else begin
                    if (wcnt >= MIN_C) begin
                        state_nxt = GAP;
                        gcnt_nxt  = ONE_C;
                    end else begin
                        state_nxt = FAULT;
                    end
                end
            end
            GAP: begin
                if (first_hi) begin
                    state_nxt = FAULT;
                end else if (second_hi) begin
                    state_nxt = P2;
                    wcnt_nxt  = ONE_C;
                end else if (gcnt >= GAP_C) begin
                    state_nxt = FAULT;
                end else begin
                    gcnt_nxt = gcnt + ONE_C;
                end
            end
            P2: begin
                if (first_hi) begin
                    state_nxt = FAULT;
                end else if (second_hi) begin
                    if (wcnt >= MAX_C) state_nxt = FAULT;
                    else               wcnt_nxt  = wcnt + ONE_C;
                end else if (wcnt >= MIN_C) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                end else begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (both_lo) state_nxt = IDLE;
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase

        // Set drops any in-flight pair by parking in FAULT silently; FAULT
        // releases to IDLE as soon as both lines are seen low.
        if (Set) begin
            state_nxt = FAULT;
            commit    = 1'b0;
        end

        if (state_nxt == IDLE || state_nxt == FAULT) begin
            wcnt_nxt = '0;
            gcnt_nxt = '0;
        end
    end

    assign enter_fault = (state_nxt == FAULT) && (state != FAULT) && !Set;
    assign Err         = err_q;
    assign Busy        = (state != IDLE);

    dekatron_ring_counter #(
        .N (N_CATHODES)
    ) u_ring (
        .clk      (hsClk),
        .rst_n    (Rst_n),
        .load     (Set),
        .load_val (In),
        .step_en  (commit),
        .step_dec (dir_dec),
        .position (Position),
        .cathodes (Cathodes),
        .step     (Step),
        .last_dec (StepDec),
        .carry    (Carry),
        .borrow   (Borrow)
    );

endmodule
